// File: rtl/stream_fifo_flushable.sv
// rtl/stream_fifo_flushable.sv - flushable valid/ready FIFO feeding one arbiter port
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous flush, drops every stored entry this cycle
//   inp_data_i   input payload
//   inp_valid_i  input valid
//   inp_ready_o  input ready (never depends on oup_ready_i)
//   oup_data_o   head entry, or inp_data_i when empty with FALL_THROUGH
//   oup_valid_o  output valid
//   oup_ready_i  downstream ready
//   usage_o      number of stored entries (0..DEPTH)

module stream_fifo_flushable #(
    parameter type         DATA_T       = logic,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  DATA_T                      inp_data_i,
    input  logic                       inp_valid_i,
    output logic                       inp_ready_o,
    output DATA_T                      oup_data_o,
    output logic                       oup_valid_o,
    input  logic                       oup_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    generate
        if (DEPTH < 1) begin : g_bad_depth
            $error("stream_fifo_flushable: DEPTH must be >= 1");
        end
    endgenerate

    DATA_T            mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass;
    logic do_write;
    logic do_read;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // While reset is held the interface looks idle-but-accepting, even if a
    // fall-through producer is already presenting data.
    assign inp_ready_o = rst_ni ? (!full && !flush_i) : 1'b1;
    assign oup_valid_o = rst_ni && !flush_i && (!empty || (FALL_THROUGH && inp_valid_i));

    always_comb begin
        oup_data_o = mem[rd_ptr];
        if (empty && FALL_THROUGH) begin
            oup_data_o = inp_data_i;
        end
    end

    assign push = inp_valid_i && inp_ready_o;
    assign pop  = oup_valid_o && oup_ready_i;

    // An entry that passes straight through an empty FIFO is consumed in the
    // same cycle and never touches storage.
    assign bypass   = FALL_THROUGH && empty && push && pop;
    assign do_write = push && !bypass;
    assign do_read  = pop && !empty;

    assign usage_o = count;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem[wr_ptr] <= inp_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_read) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty && !(FALL_THROUGH && push)));
    a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count <= FULL_CNT);

endmodule

// File: tb/tb_stream_fifo_flushable.sv
// tb/tb_stream_fifo_flushable.sv - randomized self-checking bench for stream_fifo_flushable

module tb_stream_fifo_flushable;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, FALL_THROUGH=0
    logic       a_flush, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic [2:0] a_use;
    // Instance B: DEPTH=2, FALL_THROUGH=1
    logic       b_flush, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
    logic [1:0] b_use;

    stream_fifo_flushable #(.DATA_T(logic [7:0]), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .inp_data_i(a_id), .inp_valid_i(a_iv), .inp_ready_o(a_ir),
        .oup_data_o(a_od), .oup_valid_o(a_ov), .oup_ready_i(a_or),
        .usage_o(a_use));

    stream_fifo_flushable #(.DATA_T(logic [7:0]), .DEPTH(2), .FALL_THROUGH(1'b1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .inp_data_i(b_id), .inp_valid_i(b_iv), .inp_ready_o(b_ir),
        .oup_data_o(b_od), .oup_valid_o(b_ov), .oup_ready_i(b_or),
        .usage_o(b_use));

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    // Values seen in the most recent step, for scenario-level checks.
    logic       oa_v, oa_r, ob_v, ob_r;
    logic [7:0] oa_d, ob_d;
    int         oa_u, ob_u;

    // Compare one instance against its queue model, then advance the model.
    task automatic model_step(input string tag, input int depth, input bit ft,
                              input bit v, input logic [7:0] d, input bit r, input bit f,
                              input bit act_r, input bit act_v, input logic [7:0] act_d,
                              input int act_u, inout logic [7:0] q[$]);
        bit         e_r, e_v, push, pop, was_empty;
        logic [7:0] e_d;
        e_r = (q.size() < depth) && !f;
        e_v = ((q.size() > 0) || (ft && v)) && !f;
        e_d = (q.size() > 0) ? q[0] : d;
        checks++;
        if (act_r !== e_r) begin
            errors++;
            $display("FAIL %s_ready got %0b exp %0b at %0t", tag, act_r, e_r, $time);
        end
        checks++;
        if (act_v !== e_v) begin
            errors++;
            $display("FAIL %s_valid got %0b exp %0b at %0t", tag, act_v, e_v, $time);
        end
        if (e_v) begin
            checks++;
            if (act_d !== e_d) begin
                errors++;
                $display("FAIL %s_data got %h exp %h at %0t", tag, act_d, e_d, $time);
            end
        end
        checks++;
        if (act_u != q.size()) begin
            errors++;
            $display("FAIL %s_usage got %0d exp %0d at %0t", tag, act_u, q.size(), $time);
        end
        push = v && e_r;
        pop  = e_v && r;
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
        end else begin
            if (pop && !was_empty) void'(q.pop_front());
            if (push && !(was_empty && ft && pop)) q.push_back(d);
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step2(input bit va, input logic [7:0] da, input bit ra, input bit fa,
                         input bit vb, input logic [7:0] db, input bit rb, input bit fb);
        a_iv = va; a_id = da; a_or = ra; a_flush = fa;
        b_iv = vb; b_id = db; b_or = rb; b_flush = fb;
        #1;
        oa_v = a_ov; oa_r = a_ir; oa_d = a_od; oa_u = int'(a_use);
        ob_v = b_ov; ob_r = b_ir; ob_d = b_od; ob_u = int'(b_use);
        model_step("a", 4, 1'b0, va, da, ra, fa, a_ir, a_ov, a_od, int'(a_use), qa);
        model_step("b", 2, 1'b1, vb, db, rb, fb, b_ir, b_ov, b_od, int'(b_use), qb);
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input bit v, input logic [7:0] d, input bit r, input bit f);
        step2(v, d, r, f, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic step_b(input bit v, input logic [7:0] d, input bit r, input bit f);
        step2(1'b0, 8'h00, 1'b0, 1'b0, v, d, r, f);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 8 && qa.size() > 0; i++) step_a(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        a_iv = 0; a_id = 0; a_or = 0; a_flush = 0;
        b_iv = 0; b_id = 0; b_or = 0; b_flush = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_use !== 3'd0) begin
            errors++;
            $display("FAIL reset_a got v=%0b r=%0b u=%0d exp v=0 r=1 u=0", a_ov, a_ir, a_use);
        end
        checks++;
        if (b_ov !== 1'b0 || b_ir !== 1'b1 || b_use !== 2'd0) begin
            errors++;
            $display("FAIL reset_b got v=%0b r=%0b u=%0d exp v=0 r=1 u=0", b_ov, b_ir, b_use);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_order();
        int peak = 0;
        logic [7:0] seen[$];
        step_a(1'b1, 8'hA1, 1'b1, 1'b0);
        checks++;
        if (oa_v !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got valid=%0b exp 0", oa_v);
        end
        step_a(1'b1, 8'hA2, 1'b1, 1'b0); if (oa_v) seen.push_back(oa_d); if (oa_u > peak) peak = oa_u;
        step_a(1'b1, 8'hA3, 1'b1, 1'b0); if (oa_v) seen.push_back(oa_d); if (oa_u > peak) peak = oa_u;
        step_a(1'b0, 8'h00, 1'b1, 1'b0); if (oa_v) seen.push_back(oa_d); if (oa_u > peak) peak = oa_u;
        checks++;
        if (seen.size() != 3 || seen[0] !== 8'hA1 || seen[1] !== 8'hA2 || seen[2] !== 8'hA3) begin
            errors++;
            $display("FAIL basic_order got %p exp A1 A2 A3", seen);
        end
        checks++;
        if (peak != 1) begin
            errors++;
            $display("FAIL basic_peak_usage got %0d exp 1", peak);
        end
    endtask

    task automatic test_full_wrap();
        logic [7:0] nxt;
        logic [7:0] seen[$];
        for (int i = 0; i < 4; i++) step_a(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step_a(1'b1, 8'h14, 1'b0, 1'b0);
        checks++;
        if (oa_r !== 1'b0 || oa_u != 4) begin
            errors++;
            $display("FAIL full_ready got r=%0b u=%0d exp r=0 u=4", oa_r, oa_u);
        end
        nxt = 8'h14;
        for (int i = 0; i < 40 && seen.size() < 8; i++) begin
            step_a(nxt <= 8'h17, nxt, 1'b1, 1'b0);
            if (oa_v) seen.push_back(oa_d);
            if (oa_r && nxt <= 8'h17) nxt++;
        end
        checks++;
        if (seen.size() != 8) begin
            errors++;
            $display("FAIL wrap_count got %0d exp 8", seen.size());
        end
        for (int i = 0; i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL wrap_order[%0d] got %h exp %h", i, seen[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        drain_a();
        step_a(1'b1, 8'h55, 1'b0, 1'b0);
        step_a(1'b1, 8'h56, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step_a(1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (oa_v !== 1'b1 || oa_d !== 8'h55 || oa_u != 2) begin
                errors++;
                $display("FAIL hold[%0d] got v=%0b d=%h u=%0d exp v=1 d=55 u=2", i, oa_v, oa_d, oa_u);
            end
        end
    endtask

    task automatic test_flush();
        step_a(1'b1, 8'h57, 1'b0, 1'b0);
        checks++;
        if (oa_u != 2) begin
            errors++;
            $display("FAIL flush_pre got usage %0d exp 2", oa_u);
        end
        step_a(1'b1, 8'h77, 1'b0, 1'b1);
        checks++;
        if (oa_r !== 1'b0 || oa_v !== 1'b0 || oa_u != 3) begin
            errors++;
            $display("FAIL flush_cycle got r=%0b v=%0b u=%0d exp r=0 v=0 u=3", oa_r, oa_v, oa_u);
        end
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (oa_u != 0 || oa_v !== 1'b0) begin
            errors++;
            $display("FAIL flush_after got u=%0d v=%0b exp u=0 v=0", oa_u, oa_v);
        end
    endtask

    task automatic test_fall_through();
        step_b(1'b1, 8'h3C, 1'b1, 1'b0);
        checks++;
        if (ob_v !== 1'b1 || ob_d !== 8'h3C || ob_u != 0) begin
            errors++;
            $display("FAIL ft_same_cycle got v=%0b d=%h u=%0d exp v=1 d=3c u=0", ob_v, ob_d, ob_u);
        end
        step_b(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (ob_u != 0 || ob_v !== 1'b0) begin
            errors++;
            $display("FAIL ft_after got u=%0d v=%0b exp u=0 v=0", ob_u, ob_v);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step_a(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        a_iv = 0; a_or = 0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_ov !== 1'b0 || a_use !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got v=%0b u=%0d exp v=0 u=0", a_ov, a_use);
        end
        qa.delete();
        qb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step_a(1'b1, 8'h01, 1'b0, 1'b0);
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (oa_v !== 1'b1 || oa_d !== 8'h01 || oa_u != 1) begin
            errors++;
            $display("FAIL post_reset got v=%0b d=%h u=%0d exp v=1 d=01 u=1", oa_v, oa_d, oa_u);
        end
        step_a(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (oa_v !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_alone got v=%0b exp 0", oa_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step2($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full_wrap();
        test_backpressure();
        test_flush();
        test_fall_through();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
